// File: rtl/qif_neuron_array.sv
// Array of independent quadratic integrate-and-fire neurons with refractory
// hold and saturating per-channel spike counters.
module qif_neuron_array #(
    parameter int        N      = 4,
    parameter int        W      = 8,
    parameter int        FRAC   = 4,
    parameter int signed VPEAK  = 50,
    parameter int signed VRESET = -20,
    parameter int        REFRAC = 3,
    parameter int        CNTW   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clr_cnt,
    input  logic [N*W-1:0]    i_in,
    output logic [N*W-1:0]    v_out,
    output logic [N-1:0]      spike_out,
    output logic [N*CNTW-1:0] spike_cnt
);

    localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
    localparam int S  = 2 * W + 2;

    localparam logic signed [W-1:0] VPEAK_V  = W'(VPEAK);
    localparam logic signed [W-1:0] VRESET_V = W'(VRESET);
    localparam logic [RW-1:0]       REFRAC_V = RW'(REFRAC);

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_ch
            logic signed [W-1:0]   v_q, v_d;
            logic [RW-1:0]         ref_q, ref_d;
            logic [CNTW-1:0]       cnt_q, cnt_d;
            logic                  spike_q, spike_d;

            logic signed [W-1:0]   i_c;
            logic signed [2*W-1:0] v_wide;
            logic [2*W-1:0]        sq;
            logic [2*W-1:0]        sq_sh;
            logic signed [S-1:0]   sum;
            logic signed [W-1:0]   v_int;
            logic                  fire;

            assign i_c    = i_in[gi*W +: W];
            assign v_wide = {{W{v_q[W-1]}}, v_q};
            // The square of a sign-extended value is non-negative, so the low 2W bits are exact.
            assign sq     = v_wide * v_wide;
            assign sq_sh  = sq >> FRAC;
            assign sum    = {{(S-W){v_q[W-1]}}, v_q} + {2'b00, sq_sh}
                          + {{(S-W){i_c[W-1]}}, i_c};
            assign fire   = (v_q >= VPEAK_V);

            // The sum fits in W bits only when every bit above the W-bit sign bit matches it.
            always_comb begin
                if (sum[S-1:W-1] == {(S-W+1){sum[S-1]}}) begin
                    v_int = sum[W-1:0];
                end else if (sum[S-1]) begin
                    v_int = {1'b1, {(W-1){1'b0}}};
                end else begin
                    v_int = {1'b0, {(W-1){1'b1}}};
                end
            end

            always_comb begin
                v_d     = v_q;
                ref_d   = ref_q;
                cnt_d   = cnt_q;
                spike_d = 1'b0;
                if (en) begin
                    if (fire) begin
                        v_d     = VRESET_V;
                        ref_d   = REFRAC_V;
                        spike_d = 1'b1;
                    end else if (ref_q != '0) begin
                        v_d   = VRESET_V;
                        ref_d = ref_q - 1'b1;
                    end else begin
                        v_d = v_int;
                    end
                end
                // A spike in the same cycle as a clear counts as the first event afterwards.
                if (en && fire) begin
                    if (clr_cnt) begin
                        cnt_d = CNTW'(1);
                    end else if (!(&cnt_q)) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (clr_cnt) begin
                    cnt_d = '0;
                end
            end

            always_ff @(posedge clk or posedge rst_n) begin
                if (rst_n) begin
                    v_q     <= VRESET_V;
                    ref_q   <= '0;
                    cnt_q   <= '0;
                    spike_q <= 1'b0;
                end else begin
                    v_q     <= v_d;
                    ref_q   <= ref_d;
                    cnt_q   <= cnt_d;
                    spike_q <= spike_d;
                end
            end

            assign v_out[gi*W +: W]          = v_q;
            assign spike_out[gi]             = spike_q;
            assign spike_cnt[gi*CNTW +: CNTW] = cnt_q;
        end
    endgenerate

endmodule

// File: doc/qif_neuron_array.md
# qif_neuron_array

Parametrised array of N independent quadratic integrate-and-fire neurons with a W-bit signed membrane state. Each channel integrates V + (V²>>>FRAC) + I per enabled cycle, saturates, fires at VPEAK, resets to VRESET and enters a programmable refractory period. Each channel also keeps a saturating spike counter. The block sits between the stimulus/synapse front end (per-channel currents) and spike readout/encoding logic.

## Interface
Parameters:
- N, 4, number of neuron channels
- W, 8, membrane/input width (signed two's complement)
- FRAC, 4, right-shift applied to V² (quadratic gain 2^-FRAC)
- VPEAK, 50, signed firing threshold (V >= VPEAK fires)
- VRESET, -20, signed post-spike and reset potential
- REFRAC, 3, refractory length in enabled cycles (0 allowed)
- CNTW, 8, spike-counter width per channel

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-high
- en  in  1  global step enable; 0 freezes all channel state
- clr_cnt  in  1  synchronous clear of all spike counters
- i_in  in  N*W  per-channel signed input current, channel c at bits [c*W +: W]
- v_out  out  N*W  per-channel membrane potential (registered state), same packing
- spike_out  out  N  per-channel spike pulse, registered
- spike_cnt  out  N*CNTW  per-channel saturating spike count, channel c at [c*CNTW +: CNTW]

## Operation
- Per-channel state: V (W-bit signed), ref (refractory counter, width clog2(REFRAC+1), min 1), cnt (CNTW), spike (1).
- Reset (rst_n=1): V=VRESET, ref=0, cnt=0, spike=0 for all channels; v_out = VRESET, spike_out = 0, spike_cnt = 0.
- When en=1, each channel independently selects one update per edge, in priority order:
  - FIRE: V >= VPEAK (signed compare) -> V<=VRESET, spike<=1, ref<=REFRAC, cnt<=cnt+1 (saturating).
  - REFRACTORY: ref != 0 -> V<=VRESET, ref<=ref-1, spike<=0; i_in ignored.
  - INTEGRATE: otherwise -> V<=sat(V + ((V*V)>>FRAC) + i_in), spike<=0.
- en=0: V, ref and cnt hold; spike<=0 (pulses never stretch). clr_cnt still acts.
- Arithmetic: V*V is computed at full 2W bits (non-negative). Shift it logically by FRAC. Sign-extend V and i_in, then sum at 2W+2 bits. Saturate to [-2^(W-1), 2^(W-1)-1]; no wrap-around is permitted.
- Counter: saturates at 2^CNTW-1. clr_cnt=1 forces cnt to 0, but a FIRE in the same cycle yields cnt=1; clear applies regardless of en.
- Channels share only clk, rst_n, en and clr_cnt. There is no cross-channel coupling.
- Parameter sanity: VRESET < VPEAK, and both are representable in W bits.

## Timing
- Single-cycle state update. v_out and spike_out are direct register outputs, with no combinational path from i_in.
- i_in sampled at edge k affects v_out from cycle k+1.
- spike_out is high for exactly one cycle, the same cycle v_out first shows VRESET after a threshold crossing. The threshold value itself is visible on v_out one cycle earlier.
- After FIRE, v_out stays at VRESET for 1+REFRAC enabled cycles. Integration resumes on the next enabled edge.
- Minimum inter-spike interval per channel is 2+REFRAC enabled cycles (FIRE, REFRAC holds, then at least one integrate).
- Asynchronous reset mid-operation (including during refractory) clears immediately. The first post-reset enabled edge performs INTEGRATE from VRESET.
- en deasserted mid-refractory pauses the ref countdown; the countdown resumes when en returns.

## Test plan
- Defaults, en=1, i_in=0 on channel 0: v_out sequence -20,5,6,8,12,21,48,127 (48+144 saturates). Next cycle v_out=-20 with spike_out[0]=1, then -20 for 3 more cycles, then 5. spike_cnt[0]=1.
- Channel 1 i_in=-10 from reset: v_out -20,-5,-14,-12,-13,-13 (fixed point). No spike ever; channels 0/2/3 are unaffected by channel 1 stimulus.
- Saturation check at V=48, i_in=+127: v_out=127, not a wrapped value. With i_in=-128 from V=-20: v_out=-123.
- en toggling: drop en for 5 cycles during refractory. v_out, ref and cnt hold, and spike_out stays 0. After en returns, the remaining refractory cycles complete before integration.
- Counter: CNTW=2, drive repeated spikes; spike_cnt saturates at 3. clr_cnt coincident with a spike gives 1; clr_cnt alone gives 0.
- Reset mid-refractory and mid-integration (assert rst_n asynchronously between edges): outputs go immediately to v_out=-20, spike_out=0, spike_cnt=0. With REFRAC=0, rerun test 1 and check 5 follows the spike cycle directly.
